// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a single-port word-wide SRAM; one INCR burst (<=16 beats) in flight,
// round-robin between AR and AW.
`timescale 1ns/1ps
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned AXI_IDS_BITS  = 8,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned AXI_LEN_BITS  = 4,
  parameter int unsigned AXI_SIZE_BITS = 3,
  parameter int unsigned AXI_DATA_BITS = 32,
  parameter int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  ARID_S,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  output logic [AXI_IDS_BITS-1:0]  RID_S,
  output logic [AXI_DATA_BITS-1:0] RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  input  logic [AXI_IDS_BITS-1:0]  AWID_S,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
  input  logic [1:0]               AWBURST_S,
  input  logic                     AWVALID_S,
  output logic                     AWREADY_S,
  input  logic [AXI_DATA_BITS-1:0] WDATA_S,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
  input  logic                     WLAST_S,
  input  logic                     WVALID_S,
  output logic                     WREADY_S,
  output logic [AXI_IDS_BITS-1:0]  BID_S,
  output logic [1:0]               BRESP_S,
  output logic                     BVALID_S,
  input  logic                     BREADY_S,
  output logic                     sram_ceb,
  output logic                     sram_web,
  output logic [AXI_DATA_BITS-1:0] sram_bweb,
  output logic [ADDR_WIDTH-1:0]    sram_a,
  output logic [AXI_DATA_BITS-1:0] sram_di,
  input  logic [AXI_DATA_BITS-1:0] sram_do
);

  typedef enum logic [2:0] {StIdle, StRReq, StRResp, StWData, StWResp} state_e;

  state_e                   state_q;
  logic                     prio_w_q;
  logic                     err_q;
  logic [AXI_IDS_BITS-1:0]  id_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [AXI_LEN_BITS-1:0]  len_q;
  logic [AXI_LEN_BITS-1:0]  beat_q;
  logic [ADDR_WIDTH-1:0]    a_hold_q;
  logic [AXI_DATA_BITS-1:0] di_hold_q;

  logic ar_hs, aw_hs, w_hs, rd_acc, last_beat;
  logic [AXI_DATA_BITS-1:0] strb_bweb;

  logic unused_inputs;
  assign unused_inputs = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S,
                           ARADDR_S[1:0], AWADDR_S[1:0],
                           ARADDR_S[AXI_ADDR_BITS-1:ADDR_WIDTH+2],
                           AWADDR_S[AXI_ADDR_BITS-1:ADDR_WIDTH+2]};

  assign ARREADY_S = (state_q == StIdle) & ~(AWVALID_S & prio_w_q);
  assign AWREADY_S = (state_q == StIdle) & ~(ARVALID_S & ~prio_w_q);
  assign ar_hs     = ARVALID_S & ARREADY_S;
  assign aw_hs     = AWVALID_S & AWREADY_S;
  assign w_hs      = (state_q == StWData) & WVALID_S;
  assign rd_acc    = (state_q == StRReq);
  assign last_beat = (beat_q == len_q);

  always_comb begin
    strb_bweb = '1;
    for (int i = 0; i < int'(AXI_STRB_BITS); i++) begin
      strb_bweb[8*i +: 8] = {8{~WSTRB_S[i]}};
    end
  end

  // Address and write data hold their last driven value between accesses.
  assign sram_ceb  = ~(rd_acc | w_hs);
  assign sram_web  = ~w_hs;
  assign sram_bweb = w_hs ? strb_bweb : '1;
  assign sram_a    = (rd_acc | w_hs) ? addr_q : a_hold_q;
  assign sram_di   = w_hs ? WDATA_S : di_hold_q;

  assign RVALID_S = (state_q == StRResp);
  assign RDATA_S  = RVALID_S ? sram_do : '0;
  assign RID_S    = id_q;
  assign RLAST_S  = RVALID_S & last_beat;
  assign RRESP_S  = 2'b00;
  assign WREADY_S = (state_q == StWData);
  assign BVALID_S = (state_q == StWResp);
  assign BID_S    = id_q;
  assign BRESP_S  = (BVALID_S & err_q) ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      prio_w_q  <= 1'b0;
      err_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      a_hold_q  <= '0;
      di_hold_q <= '0;
    end else begin
      if (rd_acc | w_hs) a_hold_q <= addr_q;
      if (w_hs) di_hold_q <= WDATA_S;
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            id_q     <= ARID_S;
            addr_q   <= ARADDR_S[ADDR_WIDTH+1:2];
            len_q    <= ARLEN_S;
            beat_q   <= '0;
            prio_w_q <= 1'b1;
            state_q  <= StRReq;
          end else if (aw_hs) begin
            id_q     <= AWID_S;
            addr_q   <= AWADDR_S[ADDR_WIDTH+1:2];
            len_q    <= AWLEN_S;
            beat_q   <= '0;
            prio_w_q <= 1'b0;
            state_q  <= StWData;
          end
        end
        StRReq: state_q <= StRResp;
        StRResp: begin
          if (RREADY_S) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              addr_q  <= addr_q + 1'b1;
              beat_q  <= beat_q + 1'b1;
              state_q <= StRReq;
            end
          end
        end
        StWData: begin
          if (WVALID_S) begin
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 1'b1;
            // WLAST ends the burst; any disagreement with AWLEN is reported as SLVERR.
            if (WLAST_S) begin
              state_q <= StWResp;
              if (!last_beat) err_q <= 1'b1;
            end else if (last_beat) begin
              err_q <= 1'b1;
            end
          end
        end
        StWResp: begin
          if (BREADY_S) begin
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
